// File: rtl/alt_run_pkg.sv
// Shared types and helpers for the alternating-run detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alt_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int THR_MIN = 2;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/alt_run_detector_if.sv
// Control/status bundle between the serial sampler and the run detector (ALT_RUN_STATS_EN adds match_cnt).
// Latency: n/a (wires only).
// Backpressure: none; samples are qualified by in_valid only.
interface alt_run_detector_if #(parameter int CNT_W = 4);

    logic             in_valid;
    logic             a;
    logic             clr;
    logic             thr_ovr_en;
    logic [CNT_W-1:0] thr;
    logic             match;
    logic             locked;
    logic [CNT_W-1:0] run_len;
`ifdef ALT_RUN_STATS_EN
    logic [15:0]      match_cnt;

    modport master (output in_valid, a, clr, thr_ovr_en, thr,
                    input  match, locked, run_len, match_cnt);
    modport slave  (input  in_valid, a, clr, thr_ovr_en, thr,
                    output match, locked, run_len, match_cnt);
`else
    modport master (output in_valid, a, clr, thr_ovr_en, thr,
                    input  match, locked, run_len);
    modport slave  (input  in_valid, a, clr, thr_ovr_en, thr,
                    output match, locked, run_len);
`endif

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with sync clear and sync restart-to-one.
// Latency: 1 cycle from control to q.
// Backpressure: none.
module sat_counter
    import alt_run_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         restart,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (restart) begin
            q <= W'(1);
        end else if (inc) begin
            q <= W'(sat_inc(32'(q), W));
        end
    end

endmodule

// File: rtl/alt_run_detector.sv
// Measures the current alternating-bit run and flags when it reaches a threshold (ALT_RUN_STATS_EN adds match_cnt).
// Latency: all outputs registered, valid one clk after the capturing edge.
// Backpressure: none; bubbles (in_valid=0) hold state without breaking the run.
module alt_run_detector
    import alt_run_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int THR_DEF = 4
) (
    input  logic             clk,
    input  logic             rst,
    alt_run_detector_if.slave bus
);

    state_t           state_q, state_d;
    logic             last_q;
    logic             match_q, match_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] thr_sel, thr_eff, len_nxt;
    logic             accept, restart, inc;

    always_comb begin
        thr_sel = bus.thr_ovr_en ? bus.thr : CNT_W'(THR_DEF);
        thr_eff = (thr_sel < CNT_W'(THR_MIN)) ? CNT_W'(THR_MIN) : thr_sel;
        accept  = bus.in_valid && !bus.clr;
        // A repeated bit starts a new run of length one, as does the first bit out of IDLE.
        restart = accept && ((state_q == IDLE) || (bus.a == last_q));
        inc     = accept && !restart;
        len_nxt = restart ? CNT_W'(1) : CNT_W'(sat_inc(32'(run_len), CNT_W));
    end

    always_comb begin
        state_d  = state_q;
        match_d  = 1'b0;
        locked_d = locked_q;
        if (bus.clr) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end else if (bus.in_valid) begin
            state_d  = (len_nxt >= thr_eff) ? LOCK : RUN;
            match_d  = (state_q == RUN) && (state_d == LOCK);
            locked_d = (state_d == LOCK);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b0;
            match_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            if (accept) begin
                last_q <= bus.a;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_run_len (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.clr),
        .restart (restart),
        .inc     (inc),
        .q       (run_len)
    );

`ifdef ALT_RUN_STATS_EN
    logic [15:0] match_cnt;

    sat_counter #(.W(16)) u_match_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.clr),
        .restart (1'b0),
        .inc     (match_d),
        .q       (match_cnt)
    );

    assign bus.match_cnt = match_cnt;
`endif

    assign bus.match   = match_q;
    assign bus.locked  = locked_q;
    assign bus.run_len = run_len;

endmodule

// File: tb/tb_alt_run_detector.sv
// Self-checking bench for alt_run_detector: vector table, corner sequences, randomized run against a history-based model.
module tb_alt_run_detector;

    localparam int CNT_W   = 4;
    localparam int THR_DEF = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    alt_run_detector_if #(.CNT_W(CNT_W)) bus_if ();

    alt_run_detector #(.CNT_W(CNT_W), .THR_DEF(THR_DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: keeps recent accepted bits and derives run length from the alternating suffix.
    bit hist[$];
    int exp_run;
    bit exp_locked;
    bit exp_match;
    int exp_cnt;

    typedef struct {
        bit v;
        bit a;
        bit clr;
        bit ovr;
        int thr;
        int run;
        bit m;
        bit l;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_run    = 0;
        exp_locked = 1'b0;
        exp_match  = 1'b0;
        exp_cnt    = 0;
    endtask

    task automatic model_step(input bit v, input bit a, input bit clr, input bit ovr, input int thr);
        int len;
        int te;
        bit nl;
        if (clr) begin
            model_reset();
        end else if (v) begin
            hist.push_back(a);
            if (hist.size() > 24) void'(hist.pop_front());
            len = 1;
            for (int i = hist.size() - 1; i > 0; i--) begin
                if (hist[i] != hist[i-1]) len++;
                else break;
            end
            exp_run = (len > SAT) ? SAT : len;
            te = ovr ? thr : THR_DEF;
            if (te < 2) te = 2;
            nl = (exp_run >= te);
            exp_match  = nl && !exp_locked;
            exp_locked = nl;
            if (exp_match && exp_cnt < 65535) exp_cnt++;
        end else begin
            exp_match = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, advance the model, and settle just after the capturing edge.
    task automatic apply(input bit v, input bit a, input bit clr, input bit ovr, input int thr);
        @(negedge clk);
        bus_if.in_valid   = v;
        bus_if.a          = a;
        bus_if.clr        = clr;
        bus_if.thr_ovr_en = ovr;
        bus_if.thr        = CNT_W'(thr);
        model_step(v, a, clr, ovr, thr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".run_len"}, int'(bus_if.run_len), exp_run);
        check({tag, ".match"},   int'(bus_if.match),   int'(exp_match));
        check({tag, ".locked"},  int'(bus_if.locked),  int'(exp_locked));
`ifdef ALT_RUN_STATS_EN
        check({tag, ".match_cnt"}, int'(bus_if.match_cnt), exp_cnt);
`endif
    endtask

    task automatic add(input bit v, input bit a, input bit clr, input int run, input bit m, input bit l);
        vec_t e;
        e.v = v; e.a = a; e.clr = clr; e.ovr = 1'b0; e.thr = 0;
        e.run = run; e.m = m; e.l = l;
        tbl.push_back(e);
    endtask

    initial begin
        int mcount;
        bit a_r;

        // Basic lock then break, then a bubbled run that matches only on the 4th valid bit.
        add(1, 1, 0, 1, 0, 0);
        add(1, 0, 0, 2, 0, 0);
        add(1, 1, 0, 3, 0, 0);
        add(1, 0, 0, 4, 1, 1);
        add(0, 0, 0, 4, 0, 1);
        add(1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        for (int b = 0; b < 4; b++) begin
            add(1, b[0] ? 1'b0 : 1'b1, 0, b + 1, (b == 3), (b == 3));
            for (int k = 0; k < 3; k++) add(0, 0, 0, b + 1, 0, (b == 3));
        end

        rst = 1'b0;
        bus_if.in_valid   = 1'b0;
        bus_if.a          = 1'b0;
        bus_if.clr        = 1'b0;
        bus_if.thr_ovr_en = 1'b0;
        bus_if.thr        = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset.run_len", int'(bus_if.run_len), 0);
        check("reset.match",   int'(bus_if.match),   0);
        check("reset.locked",  int'(bus_if.locked),  0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].a, tbl[i].clr, tbl[i].ovr, tbl[i].thr);
            check($sformatf("tbl%0d.run_len", i), int'(bus_if.run_len), tbl[i].run);
            check($sformatf("tbl%0d.match", i),   int'(bus_if.match),   int'(tbl[i].m));
            check($sformatf("tbl%0d.locked", i),  int'(bus_if.locked),  int'(tbl[i].l));
        end

        // Saturation: 20 alternating bits, one match, run_len pinned at max.
        apply(0, 0, 1, 0, 0);
        mcount = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1, i[0], 0, 0, 0);
            if (bus_if.match) mcount++;
        end
        check("sat.match_count", mcount, 1);
        check("sat.run_len", int'(bus_if.run_len), SAT);
        check("sat.locked", int'(bus_if.locked), 1);
        apply(1, 1, 0, 0, 0);
        check("sat.hold_match", int'(bus_if.match), 0);
        check_model("sat");

        // Override with thr=0 acts as 2; then raise to 9 while locked at 6.
        apply(0, 0, 1, 1, 0);
        apply(1, 1, 0, 1, 0);
        apply(1, 0, 0, 1, 0);
        check("thr0.match", int'(bus_if.match), 1);
        for (int i = 0; i < 4; i++) apply(1, i[0] ? 1'b0 : 1'b1, 0, 1, 0);
        check("thr0.run6", int'(bus_if.run_len), 6);
        apply(1, 1, 0, 1, 9);
        check("thr9.run_len", int'(bus_if.run_len), 7);
        check("thr9.locked", int'(bus_if.locked), 0);
        check("thr9.match", int'(bus_if.match), 0);
        apply(1, 0, 0, 1, 9);
        apply(1, 1, 0, 1, 9);
        check("thr9.rematch", int'(bus_if.match), 1);
        check_model("thr9");

        // clr together with a valid sample discards the sample.
        apply(0, 0, 1, 0, 0);
        apply(1, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0);
        check("clr.pre_run", int'(bus_if.run_len), 3);
        apply(1, 0, 1, 0, 0);
        check("clr.run_len", int'(bus_if.run_len), 0);
        check("clr.locked", int'(bus_if.locked), 0);
        apply(1, 1, 0, 0, 0);
        check("clr.next_run", int'(bus_if.run_len), 1);

        // Asynchronous reset mid-run.
        for (int i = 0; i < 4; i++) apply(1, i[0], 0, 0, 0);
        check("rst.pre_locked", int'(bus_if.locked), 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst.run_len", int'(bus_if.run_len), 0);
        check("rst.locked", int'(bus_if.locked), 0);
        check("rst.match", int'(bus_if.match), 0);
        model_reset();
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        rst = 1'b1;

`ifdef ALT_RUN_STATS_EN
        apply(0, 0, 1, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) apply(1, i[0], 0, 0, 0);
            apply(1, 1'b1, 0, 0, 0);
        end
        check("stats.cnt3", int'(bus_if.match_cnt), 3);
        apply(0, 0, 1, 0, 0);
        check("stats.clr", int'(bus_if.match_cnt), 0);
`endif

        // Randomized run biased toward alternation so thresholds are reached often.
        a_r = 1'b0;
        begin
            bit ovr_r;
            int thr_r;
            ovr_r = 1'b0;
            thr_r = 0;
            for (int i = 0; i < 1500; i++) begin
                bit v_r, c_r;
                if ($urandom_range(0, 49) == 0) begin
                    ovr_r = $urandom_range(0, 1) == 1;
                    thr_r = $urandom_range(0, SAT);
                end
                v_r = $urandom_range(0, 9) < 7;
                c_r = $urandom_range(0, 59) == 0;
                if (v_r) a_r = ($urandom_range(0, 7) == 0) ? a_r : ~a_r;
                apply(v_r, a_r, c_r, ovr_r, thr_r);
                check_model($sformatf("rnd%0d", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alt_run_detector.md
Name: alt_run_detector

Overview:
- Parametrised successor to the team's single-pattern alternating-bit FSM.
- Watches a qualified serial bit stream and measures the length of the current alternating run (…0101…).
- Flags when the run reaches a runtime-programmable threshold.
- Sits after a serial input sampler; feeds link-idle/training and toggle-pattern checks.

Parameters:
- CNT_W, 4, width of the run-length counter; run length saturates at 2^CNT_W-1.
- THR_DEF, 4, threshold used when thr_ovr_en=0; must satisfy 2 <= THR_DEF <= 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  a is sampled only on cycles where in_valid=1.
- a  in  1  serial data bit.
- clr  in  1  synchronous clear; highest priority after rst.
- thr_ovr_en  in  1  1 selects thr, 0 selects THR_DEF.
- thr  in  CNT_W  runtime threshold.
- match  out  1  one-cycle pulse when the run first reaches the threshold.
- locked  out  1  level; high while the run length is at or above the threshold.
- run_len  out  CNT_W  current alternating run length, in bits.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_bit=0, run_len=0, match=0, locked=0. All outputs are registered.
- thr_eff = thr_ovr_en ? thr : THR_DEF. Any thr_eff < 2 is forced to 2.
- States:
  - IDLE: no reference bit held.
  - RUN: run_len < thr_eff.
  - LOCK: run_len >= thr_eff.
- Priority each cycle: clr > in_valid > hold.
  - clr=1: state=IDLE, run_len=0, match=0, locked=0. The in_valid sample in the same cycle is discarded.
  - in_valid=0: all state holds, match=0. Bubbles never break a run.
- in_valid=1, from IDLE: run_len=1, last_bit=a, go to RUN.
- in_valid=1, not IDLE, a != last_bit: run_len = run_len+1, saturating at 2^CNT_W-1.
- in_valid=1, not IDLE, a == last_bit: run break. run_len=1, because the new bit starts a new run.
- last_bit <= a on every accepted sample.
- Next state is LOCK if the new run_len >= thr_eff, otherwise RUN.
- match=1 for exactly one cycle, on the edge where state moves RUN→LOCK.
  - No match while staying in LOCK, including at saturation.
  - A break followed by re-reaching the threshold produces a new match.
- locked = (state==LOCK), registered.
- Latency: outputs reflect a sample one clk after the edge that captures it.
- thr change mid-run: re-evaluated only on the next accepted sample.
  - If run_len already >= the new thr_eff, that sample enters LOCK and pulses match (provided it does not break the run).
  - If thr is raised above run_len while in LOCK, the next accepted sample returns the state to RUN.
- Reset mid-run: immediate asynchronous return to IDLE.

Optional Feature:
- Macro: ALT_RUN_STATS_EN.
- Defined: adds output match_cnt [15:0]. It increments on each match pulse, saturates at 16'hFFFF, and clears on rst or clr.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package alt_run_pkg holds:
  - state enum {IDLE, RUN, LOCK}, 2 bits.
  - constant THR_MIN=2.
  - function sat_inc(value, width).
- One sub-module: sat_counter, a parametrised saturating up-counter with sync clear.
  - Instanced for run_len.
  - Instanced for match_cnt when ALT_RUN_STATS_EN is defined.

Test Plan:
- CNT_W=4, THR_DEF=4, thr_ovr_en=0; valid bits 1,0,1,0 → run_len 1,2,3,4; match pulses one cycle after the 4th bit; locked=1. A next bit of 0 → run_len=1, locked=0, no match.
- Alternating bits with in_valid low for 3 cycles between each → the run continues; match on the 4th valid bit only.
- 20 alternating bits at CNT_W=4 → run_len sticks at 15; exactly one match pulse; locked stays 1.
- thr_ovr_en=1 with thr=0 → behaves as thr=2: bits 1,0 give a match. With thr=9 set while run_len=6 in LOCK, next toggle → run_len=7, locked=0.
- clr asserted together with in_valid mid-run (run_len=3) → next cycle run_len=0, IDLE. The following bit gives run_len=1. rst pulsed mid-run → outputs zero immediately.
- ALT_RUN_STATS_EN defined: three separate runs each reaching threshold → match_cnt=3; after clr → 0.
